// File: rtl/tm1638_digit_store.sv
// Per-digit segment store between a multiplexed 7-segment driver and a static
// display peripheral. Captures the shared segment bus into each strobed digit,
// optionally blanks digits that stop being refreshed, and applies a shared
// blink phase to selected digits.
module tm1638_digit_store #(
  parameter int w_digit   = 8,
  parameter int w_seg     = 8,
  parameter int r_init    = 0,
  parameter int mode      = 1,
  parameter int timeout   = 1000,
  parameter int blink_div = 25000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [w_seg-1:0]           hgfedcba,
  input  logic [w_digit-1:0]         digit,
  input  logic [w_digit-1:0]         blink_en,
  output logic [w_digit*w_seg-1:0]   hex,
  output logic [w_digit-1:0]         stale
);

  if (mode < 0 || mode > 2) begin : g_bad_mode
    $error("tm1638_digit_store: mode must be 0, 1 or 2");
  end
  if (timeout < 2) begin : g_bad_timeout
    $error("tm1638_digit_store: timeout must be >= 2");
  end
  if (blink_div < 2) begin : g_bad_blink
    $error("tm1638_digit_store: blink_div must be >= 2");
  end
  if (w_digit < 1 || w_digit > 16) begin : g_bad_digits
    $error("tm1638_digit_store: w_digit must be 1..16");
  end

  localparam int TW = $clog2(timeout + 1);
  localparam int BW = $clog2(blink_div);
  localparam logic [TW-1:0] TMAX  = TW'(timeout);
  localparam logic [TW-1:0] TLAST = TW'(timeout - 1);
  localparam logic [BW-1:0] BLAST = BW'(blink_div - 1);

  // Decimal glyph in hgfedcba order, used for the reset pattern.
  function automatic logic [w_seg-1:0] f_glyph(input int n);
    logic [7:0] g;
    case (n % 10)
      0:       g = 8'h3F;
      1:       g = 8'h06;
      2:       g = 8'h5B;
      3:       g = 8'h4F;
      4:       g = 8'h66;
      5:       g = 8'h6D;
      6:       g = 8'h7D;
      7:       g = 8'h07;
      8:       g = 8'h7F;
      default: g = 8'h6F;
    endcase
    return w_seg'(g);
  endfunction

  logic [w_seg-1:0] r_store [w_digit];
  logic [TW-1:0]    r_timer [w_digit];
  logic [w_digit-1:0] r_stale;
  logic [BW-1:0]    r_bcnt;
  logic             r_phase;
  logic [w_seg-1:0] w_base  [w_digit];

  // Per-digit capture, stale timer and timeout blanking (capture beats timeout).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < w_digit; i++) begin
        r_store[i] <= (r_init != 0) ? f_glyph(i) : '0;
        r_timer[i] <= '0;
        r_stale[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < w_digit; i++) begin
        if (mode != 0 && digit[i]) begin
          r_store[i] <= hgfedcba;
          r_timer[i] <= '0;
          r_stale[i] <= 1'b0;
        end else if (mode == 2 && r_timer[i] < TMAX) begin
          r_timer[i] <= r_timer[i] + 1'b1;
          if (r_timer[i] == TLAST) begin
            r_store[i] <= '0;
            r_stale[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Free-running blink divider; phase starts visible and toggles on each wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (r_bcnt == BLAST) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt  <= r_bcnt + 1'b1;
    end
  end

  // Select the per-digit source and apply the shared blink phase.
  always_comb begin
    hex = '0;
    for (int i = 0; i < w_digit; i++) begin
      w_base[i] = '0;
      if (mode == 0) begin
        w_base[i] = digit[i] ? hgfedcba : '0;
      end else begin
        w_base[i] = r_store[i];
      end
      hex[i*w_seg +: w_seg] = (blink_en[i] & ~r_phase) ? '0 : w_base[i];
    end
  end

  assign stale = r_stale;

endmodule

// File: tb/tb_tm1638_digit_store.sv
// Bench for tm1638_digit_store: three instances cover sticky mode with a decimal
// init pattern and fast blink, stale-timeout mode, and passthrough mode.
module tb_tm1638_digit_store;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // sticky, 12 digits, decimal init, fast blink
  logic [7:0]  bus_s = '0;
  logic [11:0] dig_s = '0, ben_s = '0, stale_s;
  logic [95:0] hex_s;
  // stale timeout
  logic [7:0]  bus_t = '0, dig_t = '0, ben_t = '0, stale_t;
  logic [63:0] hex_t;
  // passthrough
  logic [7:0]  bus_p = '0, dig_p = '0, ben_p = '0, stale_p;
  logic [63:0] hex_p;

  tm1638_digit_store #(.w_digit(12), .w_seg(8), .r_init(1), .mode(1),
                       .timeout(1000), .blink_div(3)) u_sticky (
    .clk(clk), .rst(rst), .hgfedcba(bus_s), .digit(dig_s),
    .blink_en(ben_s), .hex(hex_s), .stale(stale_s));

  tm1638_digit_store #(.w_digit(8), .w_seg(8), .r_init(0), .mode(2),
                       .timeout(4), .blink_div(1000)) u_stale (
    .clk(clk), .rst(rst), .hgfedcba(bus_t), .digit(dig_t),
    .blink_en(ben_t), .hex(hex_t), .stale(stale_t));

  tm1638_digit_store #(.w_digit(8), .w_seg(8), .r_init(0), .mode(0),
                       .timeout(1000), .blink_div(1000)) u_pass (
    .clk(clk), .rst(rst), .hgfedcba(bus_p), .digit(dig_p),
    .blink_en(ben_p), .hex(hex_p), .stale(stale_p));

  localparam logic [95:0] INIT12 =
    96'h063F_6F7F_077D_6D66_4F5B_063F;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [11:0] dig;
    logic [7:0]  bus;
    int          idx;
    logic [7:0]  exp;
  } svec_t;

  typedef struct {
    logic [7:0]  dig;
    logic [7:0]  bus;
    logic [7:0]  ben;
    logic [63:0] exp;
  } pvec_t;

  svec_t sv[10];
  pvec_t pv[6];

  initial begin
    logic [7:0] e;

    sv[0] = '{12'h000, 8'hFF, 2,  8'h6D};
    sv[1] = '{12'h000, 8'hFF, 3,  8'h4F};
    sv[2] = '{12'h081, 8'h5B, 0,  8'h5B};
    sv[3] = '{12'h000, 8'h00, 7,  8'h5B};
    sv[4] = '{12'h000, 8'h00, 1,  8'h06};
    sv[5] = '{12'h800, 8'h80, 11, 8'h80};
    sv[6] = '{12'h000, 8'h00, 10, 8'h3F};
    sv[7] = '{12'hFFF, 8'hA5, 5,  8'hA5};
    sv[8] = '{12'h000, 8'h00, 9,  8'hA5};
    sv[9] = '{12'h010, 8'h00, 4,  8'h00};

    pv[0] = '{8'h10, 8'h3F, 8'h00, 64'h0000_003F_0000_0000};
    pv[1] = '{8'h00, 8'h3F, 8'h00, 64'h0000_0000_0000_0000};
    pv[2] = '{8'h81, 8'h5B, 8'h00, 64'h5B00_0000_0000_005B};
    pv[3] = '{8'hFF, 8'h80, 8'h00, 64'h8080_8080_8080_8080};
    pv[4] = '{8'h03, 8'h6D, 8'h03, 64'h0000_0000_0000_6D6D};
    pv[5] = '{8'h04, 8'h06, 8'h00, 64'h0000_0000_0006_0000};

    // reset held: init pattern, everything else cleared
    #12;
    check("rst_init12", hex_s, INIT12);
    check("rst_stale_s", 96'(stale_s), 96'h0);
    check("rst_hex_t", 96'(hex_t), 96'h0);
    check("rst_stale_t", 96'(stale_t), 96'h0);
    @(negedge clk) rst = 1'b0;

    // passthrough: zero-latency combinational vectors
    for (int i = 0; i < 6; i++) begin
      dig_p = pv[i].dig; bus_p = pv[i].bus; ben_p = pv[i].ben;
      #1;
      check($sformatf("pass_vec%0d", i), 96'(hex_p), 96'(pv[i].exp));
    end
    check("pass_stale", 96'(stale_p), 96'h0);

    // sticky: capture appears one edge later
    @(negedge clk) begin dig_s = 12'h004; bus_s = 8'h6D; end
    #1 check("sticky_pre_edge", 96'(hex_s[23:16]), 96'h5B);
    @(posedge clk) #1 check("sticky_post_edge", 96'(hex_s[23:16]), 96'h6D);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) begin dig_s = sv[i].dig; bus_s = sv[i].bus; end
      @(posedge clk) #1;
      check($sformatf("sticky_vec%0d", i), 96'(hex_s[sv[i].idx*8 +: 8]), 96'(sv[i].exp));
    end
    check("sticky_stale", 96'(stale_s), 96'h0);

    // blink: digit 0 blinks with period 3+3, digit 1 steady
    @(negedge clk) begin rst = 1'b1; dig_s = '0; ben_s = 12'h001; end
    #1 check("blink_rst_pattern", hex_s, INIT12);
    @(negedge clk) rst = 1'b0;
    #1 check("blink_k0", 96'(hex_s[7:0]), 96'h3F);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk) #1;
      e = ((k / 3) % 2 == 0) ? 8'h3F : 8'h00;
      check($sformatf("blink_k%0d", k), 96'(hex_s[7:0]), 96'(e));
      check($sformatf("steady_k%0d", k), 96'(hex_s[15:8]), 96'h06);
    end
    // reset during blank phase: visible immediately, full half-period after
    #2 rst = 1'b1;
    #1 check("blink_midrst", hex_s, INIT12);
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk) #1;
      e = ((k / 3) % 2 == 0) ? 8'h3F : 8'h00;
      check($sformatf("blink2_k%0d", k), 96'(hex_s[7:0]), 96'(e));
    end

    // stale timeout = 4
    @(negedge clk) begin rst = 1'b1; dig_t = 8'h08; bus_t = 8'h4F; end
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    check("to_t0_hex", 96'(hex_t[31:24]), 96'h4F);
    check("to_t0_stale", 96'(stale_t), 96'h00);
    @(negedge clk) dig_t = 8'h00;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk) #1;
      check($sformatf("to_t%0d_hex", k), 96'(hex_t[31:24]), 96'h4F);
      check($sformatf("to_t%0d_stale", k), 96'(stale_t), (k == 3) ? 96'hF7 : 96'h00);
    end
    @(posedge clk) #1;
    check("to_t4_hex", 96'(hex_t), 96'h0);
    check("to_t4_stale", 96'(stale_t), 96'hFF);

    // recapture on the exact timeout edge wins
    @(negedge clk) begin dig_t = 8'h08; bus_t = 8'h66; end
    @(posedge clk) #1 check("rc_t0_hex", 96'(hex_t[31:24]), 96'h66);
    @(negedge clk) dig_t = 8'h00;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk) #1;
      check($sformatf("rc_t%0d_hex", k), 96'(hex_t[31:24]), 96'h66);
    end
    @(negedge clk) begin dig_t = 8'h08; bus_t = 8'h7D; end
    @(posedge clk) #1;
    check("rc_t4_hex", 96'(hex_t[31:24]), 96'h7D);
    check("rc_t4_stale", 96'(stale_t), 96'hF7);
    @(negedge clk) dig_t = 8'h00;
    for (int k = 1; k <= 3; k++) @(posedge clk);
    #1 check("rc_t7_stale", 96'(stale_t), 96'hF7);
    @(posedge clk) #1;
    check("rc_t8_stale", 96'(stale_t), 96'hFF);
    check("rc_t8_hex", 96'(hex_t), 96'h0);

    // reset mid-timeout
    @(negedge clk) begin dig_t = 8'h08; bus_t = 8'h6F; end
    @(posedge clk);
    @(negedge clk) dig_t = 8'h00;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_stale", 96'(stale_t), 96'h0);
    check("midrst_hex", 96'(hex_t), 96'h0);
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 3; k++) @(posedge clk);
    #1 check("midrst_timer_restart", 96'(stale_t), 96'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
